step_clock_generator: RTL and testbench

Generates the processor/memory `clock` for the computer top level from the board's 50 MHz oscillator.
- Single-step mode: one debounced push of a board key produces exactly one clean, fixed-width clock pulse.
- Run mode: a slide switch produces a free-running slow clock at a selectable rate.
- The block also exports a cycle counter for the board display.
- It sits directly upstream of the computer block and drives its `clock` input.

---
 rtl/step_clock_generator.sv | 175 +++++++++++++++++
 tb/tb_step_clock_generator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/step_clock_generator.sv
// Clock source for the computer: debounced single-step pulses or a free-running
// slow clock, with a count of issued rising edges for the board display.
module step_clock_generator #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 4,
    parameter int RUN_HALF_PERIOD = 25000000
) (
    input  logic        clock_50MHz,
    input  logic        reset,
    input  logic        step_button_n,
    input  logic        run_mode,
    input  logic [1:0]  speed_select,
    output logic        cpu_clock,
    output logic        step_busy,
    output logic        button_level,
    output logic [31:0] cycle_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LIMIT     = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [31:0]     PULSE_RELOAD = 32'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        STEP_HIGH,
        STEP_LOW,
        RUN_HIGH,
        RUN_LOW
    } state_t;

    // Bit 3 = step_button_n, bit 2 = run_mode, bits 1:0 = speed_select.
    logic [3:0]      sync_meta_reg;
    logic [3:0]      sync_reg;
    logic            btn_sync;
    logic            run_sync;
    logic [1:0]      speed_sync;

    logic [DB_W-1:0] db_cnt_reg;
    logic            button_level_reg;
    logic            press_event_reg;

    state_t          state_reg;
    logic [31:0]     phase_reg;
    logic            cpu_clock_reg;
    logic            step_busy_reg;
    logic [31:0]     cycle_count_reg;

    logic [31:0]     half_table [4];
    logic [31:0]     run_reload;

    // Half period per speed setting, never allowed to shift down to zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_half
            localparam int SHIFTED = RUN_HALF_PERIOD >> (2 * gi);
            assign half_table[gi] = (SHIFTED < 1) ? 32'd1 : 32'(SHIFTED);
        end
    endgenerate

    assign btn_sync   = ~sync_reg[3];
    assign run_sync   = sync_reg[2];
    assign speed_sync = sync_reg[1:0];
    assign run_reload = half_table[speed_sync] - 32'd1;

    always_ff @(posedge clock_50MHz or negedge reset) begin
        if (!reset) begin
            sync_meta_reg <= 4'b1000;
            sync_reg      <= 4'b1000;
        end else begin
            sync_meta_reg <= {step_button_n, run_mode, speed_select};
            sync_reg      <= sync_meta_reg;
        end
    end

    always_ff @(posedge clock_50MHz or negedge reset) begin
        if (!reset) begin
            db_cnt_reg       <= '0;
            button_level_reg <= 1'b0;
            press_event_reg  <= 1'b0;
        end else begin
            press_event_reg <= 1'b0;
            if (btn_sync != button_level_reg) begin
                if (db_cnt_reg == DB_LIMIT) begin
                    button_level_reg <= btn_sync;
                    db_cnt_reg       <= '0;
                    press_event_reg  <= btn_sync;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end else begin
                db_cnt_reg <= '0;
            end
        end
    end

    always_ff @(posedge clock_50MHz or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            phase_reg       <= '0;
            cpu_clock_reg   <= 1'b0;
            step_busy_reg   <= 1'b0;
            cycle_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Run mode takes priority; a coincident press is discarded.
                    if (run_sync) begin
                        state_reg       <= RUN_HIGH;
                        phase_reg       <= run_reload;
                        cpu_clock_reg   <= 1'b1;
                        cycle_count_reg <= cycle_count_reg + 32'd1;
                    end else if (press_event_reg) begin
                        state_reg       <= STEP_HIGH;
                        phase_reg       <= PULSE_RELOAD;
                        cpu_clock_reg   <= 1'b1;
                        step_busy_reg   <= 1'b1;
                        cycle_count_reg <= cycle_count_reg + 32'd1;
                    end
                end
                STEP_HIGH: begin
                    if (phase_reg == 32'd0) begin
                        state_reg     <= STEP_LOW;
                        phase_reg     <= PULSE_RELOAD;
                        cpu_clock_reg <= 1'b0;
                    end else begin
                        phase_reg <= phase_reg - 32'd1;
                    end
                end
                STEP_LOW: begin
                    if (phase_reg == 32'd0) begin
                        state_reg     <= IDLE;
                        step_busy_reg <= 1'b0;
                    end else begin
                        phase_reg <= phase_reg - 32'd1;
                    end
                end
                RUN_HIGH: begin
                    // Always followed by a full low phase, even if run mode dropped.
                    if (phase_reg == 32'd0) begin
                        state_reg     <= RUN_LOW;
                        phase_reg     <= run_reload;
                        cpu_clock_reg <= 1'b0;
                    end else begin
                        phase_reg <= phase_reg - 32'd1;
                    end
                end
                RUN_LOW: begin
                    if (phase_reg == 32'd0) begin
                        if (run_sync) begin
                            state_reg       <= RUN_HIGH;
                            phase_reg       <= run_reload;
                            cpu_clock_reg   <= 1'b1;
                            cycle_count_reg <= cycle_count_reg + 32'd1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        phase_reg <= phase_reg - 32'd1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    cpu_clock_reg <= 1'b0;
                    step_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_clock    = cpu_clock_reg;
    assign step_busy    = step_busy_reg;
    assign button_level = button_level_reg;
    assign cycle_count  = cycle_count_reg;

endmodule

// File: tb/tb_step_clock_generator.sv
// Directed bench for step_clock_generator: expected cpu_clock pulses are queued
// when stimulus is applied and matched against each observed pulse.
module tb_step_clock_generator;

    localparam int D = 8;
    localparam int P = 4;
    localparam int H = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        step_button_n;
    logic        run_mode;
    logic [1:0]  speed_select;
    logic        cpu_clock;
    logic        step_busy;
    logic        button_level;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    step_clock_generator #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_CYCLES   (P),
        .RUN_HALF_PERIOD(H)
    ) dut (
        .clock_50MHz  (clk),
        .reset        (reset_n),
        .step_button_n(step_button_n),
        .run_mode     (run_mode),
        .speed_select (speed_select),
        .cpu_clock    (cpu_clock),
        .step_busy    (step_busy),
        .button_level (button_level),
        .cycle_count  (cycle_count)
    );

    typedef struct {
        int          rise;
        int          high;
        logic [31:0] cnt;
    } pulse_t;

    pulse_t      exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          rise_seen = 0;
    logic [31:0] cnt_seen = '0;
    logic        prev_cpu = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Called at every falling clock edge: record rises, score each completed pulse.
    task automatic sample();
        pulse_t e;
        if (cpu_clock === 1'b1 && !prev_cpu) begin
            rise_seen = cyc;
            cnt_seen  = cycle_count;
        end else if (cpu_clock !== 1'b1 && prev_cpu) begin
            check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rise_cycle", 32'(rise_seen), 32'(e.rise));
                check("high_width", 32'(cyc - rise_seen), 32'(e.high));
                check("count_at_rise", cnt_seen, e.cnt);
            end
        end
        prev_cpu = (cpu_clock === 1'b1);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            sample();
        end
    endtask

    task automatic tick_to(input int target);
        tick(target - cyc);
    endtask

    task automatic push(input int rise, input int high, input logic [31:0] cnt);
        pulse_t e;
        e.rise = rise;
        e.high = high;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        step_button_n = 1'b1;
        run_mode      = 1'b0;
        speed_select  = 2'd0;
        tick(3);
        check("rst_cpu_clock", 32'(cpu_clock), 32'd0);
        check("rst_step_busy", 32'(step_busy), 32'd0);
        check("rst_button_level", 32'(button_level), 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        reset_n = 1'b1;
        tick(2);
    endtask

    initial begin
        int c;
        int c2;
        int r1;
        int r10;

        reset_n       = 1'b0;
        step_button_n = 1'b1;
        run_mode      = 1'b0;
        speed_select  = 2'd0;

        // Clean press: rise 11 cycles after first low sample, 4 high / 4 low.
        do_reset();
        c = cyc;
        step_button_n = 1'b0;
        push(c + 12, P, 32'd1);
        tick(11);
        check("s1_pre_rise", 32'(cpu_clock), 32'd0);
        tick(1);
        check("s1_rise", 32'(cpu_clock), 32'd1);
        check("s1_busy_hi", 32'(step_busy), 32'd1);
        check("s1_level", 32'(button_level), 32'd1);
        check("s1_count", cycle_count, 32'd1);
        tick(4);
        check("s1_low_phase", 32'(cpu_clock), 32'd0);
        check("s1_busy_low_phase", 32'(step_busy), 32'd1);
        tick(3);
        check("s1_busy_last", 32'(step_busy), 32'd1);
        tick(1);
        check("s1_busy_end", 32'(step_busy), 32'd0);
        tick_to(c + 30);
        step_button_n = 1'b1;
        tick(40);
        check("s1_release_level", 32'(button_level), 32'd0);
        check("s1_release_count", cycle_count, 32'd1);
        check("s1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Bouncy press, then bouncy release.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step_button_n = (k % 2 == 1);
            tick(3);
        end
        check("s2_no_pulse_bounce", cycle_count, 32'd0);
        c = cyc;
        step_button_n = 1'b0;
        push(c + 12, P, 32'd1);
        tick(40);
        for (int k = 0; k < 10; k++) begin
            step_button_n = (k % 2 == 0);
            tick(3);
        end
        step_button_n = 1'b1;
        tick(40);
        check("s2_level", 32'(button_level), 32'd0);
        check("s2_count", cycle_count, 32'd1);
        check("s2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Free run at speed 0, then speed 3 from the next reload.
        do_reset();
        c = cyc;
        run_mode = 1'b1;
        r1 = c + 3;
        for (int i = 0; i < 10; i++) push(r1 + 2 * H * i, H, 32'(i + 1));
        r10 = r1 + 9 * 2 * H;
        tick_to(r10 + 1);
        check("s3_count10", cycle_count, 32'd10);
        tick_to(r10 + 10);
        speed_select = 2'd3;
        for (int j = 0; j < 4; j++) push(r10 + H + 1 + 2 * j, 1, 32'(11 + j));
        tick_to(r10 + H + 1 + 4);
        run_mode = 1'b0;
        tick(20);
        check("s3_stopped_cpu", 32'(cpu_clock), 32'd0);
        check("s3_count_final", cycle_count, 32'd14);
        check("s3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Run stop mid high phase; a press during run is dropped.
        do_reset();
        c = cyc;
        run_mode = 1'b1;
        r1 = c + 3;
        push(r1, H, 32'd1);
        tick_to(r1 + 9);
        run_mode = 1'b0;
        tick_to(r1 + 70);
        step_button_n = 1'b0;
        tick(20);
        step_button_n = 1'b1;
        tick_to(r1 + 128);
        check("s4_idle_cpu", 32'(cpu_clock), 32'd0);
        tick_to(r1 + 200);
        check("s4_count", cycle_count, 32'd1);
        check("s4_busy", 32'(step_busy), 32'd0);
        c = cyc;
        step_button_n = 1'b0;
        push(c + 12, P, 32'd2);
        tick(30);
        step_button_n = 1'b1;
        tick(30);
        check("s4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during STEP_HIGH; held button needs a full fresh debounce.
        do_reset();
        c = cyc;
        step_button_n = 1'b0;
        push(c + 12, 2, 32'd1);
        tick_to(c + 13);
        reset_n = 1'b0;
        #1;
        check("s5_rst_cpu", 32'(cpu_clock), 32'd0);
        check("s5_rst_count", cycle_count, 32'd0);
        check("s5_rst_level", 32'(button_level), 32'd0);
        tick(5);
        c2 = cyc;
        reset_n = 1'b1;
        push(c2 + 12, P, 32'd1);
        tick(11);
        check("s5_pre_rise", 32'(cpu_clock), 32'd0);
        tick(1);
        check("s5_rise", 32'(cpu_clock), 32'd1);
        tick(20);
        step_button_n = 1'b1;
        tick(20);

        // Counter wrap.
        force dut.cycle_count_reg = 32'hFFFF_FFFF;
        tick(1);
        release dut.cycle_count_reg;
        tick(1);
        check("s6_forced", cycle_count, 32'hFFFF_FFFF);
        c = cyc;
        step_button_n = 1'b0;
        push(c + 12, P, 32'd0);
        tick(20);
        step_button_n = 1'b1;
        tick(20);
        check("s6_wrapped", cycle_count, 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
